// File: rtl/viterbi_decoder.sv
// Hard-decision rate-1/2 Viterbi decoder with register-exchange survivors.
// Define VITERBI_ERASURE_EN to add the in_erase port for depunctured input.
module viterbi_decoder #(
  parameter int K    = 3,
  parameter int G0   = 7,
  parameter int G1   = 5,
  parameter int D    = 15,
  parameter int PM_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sym,
`ifdef VITERBI_ERASURE_EN
  input  logic [1:0] in_erase,
`endif
  input  logic       in_last,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last
);
  localparam int S  = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam int FW = $clog2(D + 1);
  localparam int IW = $clog2(D);
  localparam logic [PM_W-1:0] PM_MAX = '1;
  localparam logic [FW-1:0] FILL_D = FW'(D);
  localparam logic [K-1:0] GA = K'(G0);
  localparam logic [K-1:0] GB = K'(G1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t          state;
  logic [PM_W-1:0] pm [S];
  logic [D-1:0]    surv [S];
  logic [FW-1:0]   fill;
  logic [FW-1:0]   rem;
  logic [D-1:0]    frz;
  logic            pend;
  logic            pend_run;
  logic            pend_last;

  logic [1:0]      mask;
  logic            accept;
  logic [FW-1:0]   fill_nxt;
  logic            run_out;
  logic [IW-1:0]   ridx;
  logic [PM_W-1:0] pm_acs [S];
  logic [PM_W-1:0] pm_nrm [S];
  logic [PM_W-1:0] pm_min;
  logic [D-1:0]    surv_nxt [S];
  logic [SW-1:0]   best;
  logic [PM_W-1:0] best_pm;

  function automatic logic [1:0] code(
    input logic [SW-1:0] p,
    input logic          u
  );
    logic [K-1:0] r;
    r = {u, p};
    return {^(GA & r), ^(GB & r)};
  endfunction

  function automatic logic [1:0] hd(input logic [1:0] x);
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(
    input logic [PM_W-1:0] a,
    input logic [1:0]      b
  );
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

`ifdef VITERBI_ERASURE_EN
  assign mask = ~in_erase;
`else
  assign mask = 2'b11;
`endif

  assign accept   = in_valid & in_ready;
  assign fill_nxt = (fill == FILL_D) ? fill : fill + FW'(1);
  assign run_out  = fill_nxt == FILL_D;
  assign ridx     = IW'(rem - FW'(1));

  // One ACS unit per state; predecessors differ only in the shifted-out bit.
  for (genvar n = 0; n < S; n++) begin : g_acs
    localparam logic [SW-1:0] NS = SW'(n);
    localparam logic [SW-1:0] PA = {NS[SW-2:0], 1'b0};
    localparam logic [SW-1:0] PB = {NS[SW-2:0], 1'b1};
    localparam logic          U  = NS[SW-1];
    logic [PM_W-1:0] ca;
    logic [PM_W-1:0] cb;
    logic            pick;
    assign ca = sat_add(pm[PA], hd((in_sym ^ code(PA, U)) & mask));
    assign cb = sat_add(pm[PB], hd((in_sym ^ code(PB, U)) & mask));
    assign pick = cb < ca;
    assign pm_acs[n] = pick ? cb : ca;
    assign pm_nrm[n] = pm_acs[n] - pm_min;
    assign surv_nxt[n] = pick ? {surv[PB][D-2:0], U}
                              : {surv[PA][D-2:0], U};
  end

  always_comb begin
    pm_min = pm_acs[0];
    for (int n = 1; n < S; n++)
      if (pm_acs[n] < pm_min) pm_min = pm_acs[n];
  end

  always_comb begin
    best    = '0;
    best_pm = pm[0];
    for (int n = 1; n < S; n++)
      if (pm[n] < best_pm) begin
        best    = SW'(n);
        best_pm = pm[n];
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      fill      <= '0;
      rem       <= '0;
      frz       <= '0;
      pend      <= 1'b0;
      pend_run  <= 1'b0;
      pend_last <= 1'b0;
      for (int n = 0; n < S; n++) begin
        pm[n]   <= (n == 0) ? '0 : PM_MAX;
        surv[n] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pend      <= 1'b0;
      if (accept) begin
        for (int n = 0; n < S; n++) begin
          pm[n]   <= pm_nrm[n];
          surv[n] <= surv_nxt[n];
        end
        fill      <= fill_nxt;
        pend      <= 1'b1;
        pend_run  <= run_out;
        pend_last <= in_last;
        if (in_last) begin
          state    <= FLUSH;
          in_ready <= 1'b0;
          rem      <= run_out ? FW'(D - 1) : fill_nxt;
        end else if (run_out) begin
          state <= RUN;
        end
      end
      // Output slot of the previous accept; the last one also freezes the tail.
      if (pend) begin
        if (pend_run) begin
          out_valid <= 1'b1;
          out_bit   <= surv[best][D-1];
        end
        if (pend_last) frz <= surv[best];
      end else if (state == FLUSH) begin
        if (rem != '0) begin
          out_valid <= 1'b1;
          out_bit   <= frz[ridx];
          out_last  <= rem == FW'(1);
          rem       <= rem - FW'(1);
        end else begin
          state    <= FILL;
          in_ready <= 1'b1;
          fill     <= '0;
          for (int n = 0; n < S; n++) begin
            pm[n]   <= (n == 0) ? '0 : PM_MAX;
            surv[n] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder (K=3, G=7/5, D=15).
// Erasure scenario is compiled only with VITERBI_ERASURE_EN.
`timescale 1ns/1ps
module tb_viterbi_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [1:0] in_sym = 2'b00;
`ifdef VITERBI_ERASURE_EN
  logic [1:0] in_erase = 2'b00;
  logic [1:0] ers [64];
`endif
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int low_cnt = 0;
  int acc_cyc = 0;
  logic [1:0] syms [64];
  logic obits [$];
  logic olast [$];
  int   ocyc [$];

  viterbi_decoder #(
    .K(3), .G0(7), .G1(5), .D(15), .PM_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sym(in_sym),
`ifdef VITERBI_ERASURE_EN
    .in_erase(in_erase),
`endif
    .in_last(in_last),
    .out_valid(out_valid),
    .out_bit(out_bit),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      obits.push_back(out_bit);
      olast.push_back(out_last);
      ocyc.push_back(cyc);
    end
    if (!rst && !in_ready) low_cnt <= low_cnt + 1;
  end

  function automatic logic [63:0] pack_bits(input int base, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], obits[base+i]};
    return v;
  endfunction

  function automatic logic [63:0] pack_last(input int base, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], olast[base+i]};
    return v;
  endfunction

  // Reference encoder for G=7/5: c0 = u^s1^s0, c1 = u^s0.
  task automatic encode(input logic [63:0] bits, input int off, input int n);
    logic [1:0] s;
    logic u;
    s = 2'b00;
    for (int i = 0; i < n; i++) begin
      u = bits[n-1-i];
      syms[off+i] = {u ^ s[1] ^ s[0], u ^ s[0]};
`ifdef VITERBI_ERASURE_EN
      ers[off+i] = 2'b00;
`endif
      s = {u, s[1]};
    end
  endtask

  task automatic send_seq(input int off, input int n,
                          input logic last, input logic hold);
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      in_valid = 1'b1;
      in_sym   = syms[off+i];
      in_last  = last && (i == n - 1);
`ifdef VITERBI_ERASURE_EN
      in_erase = ers[off+i];
`endif
      while (!in_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: symbol %0d not accepted, in_ready=%0b required 1", i, in_ready);
      end
      if (i == 0) acc_cyc = cyc;
      @(negedge clk);
    end
    in_last = 1'b0;
`ifdef VITERBI_ERASURE_EN
    in_erase = 2'b00;
`endif
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_last(input int bound);
    int g;
    g = 0;
    while (!(out_valid && out_last) && g < bound) begin
      @(negedge clk);
      g++;
    end
    if (g >= bound) begin
      tests++;
      fails++;
      $display("FAIL out_last_timeout: no out_last in %0d cycles, required one", bound);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic load_block6();
    syms[0] = 2'b11; syms[1] = 2'b10; syms[2] = 2'b00;
    syms[3] = 2'b01; syms[4] = 2'b01; syms[5] = 2'b11;
`ifdef VITERBI_ERASURE_EN
    for (int i = 0; i < 6; i++) ers[i] = 2'b00;
`endif
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    tests++;
    if (out_bit !== 1'b0) begin
      fails++; $display("FAIL reset_out_bit: got %0b required 0", out_bit);
    end
    tests++;
    if (out_last !== 1'b0) begin
      fails++; $display("FAIL reset_out_last: got %0b required 0", out_last);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_block();
    int base;
    int low0;
    load_block6();
    base = obits.size();
    low0 = low_cnt;
    send_seq(0, 6, 1'b1, 1'b0);
    wait_last(60);
    tests++;
    if (obits.size() - base != 6) begin
      fails++; $display("FAIL block_count: got %0d required 6", obits.size() - base);
    end
    tests++;
    if (pack_bits(base, 6) !== 64'b101100) begin
      fails++; $display("FAIL block_bits: got %b required 101100", pack_bits(base, 6));
    end
    tests++;
    if (pack_last(base, 6) !== 64'b000001) begin
      fails++; $display("FAIL block_last: got %b required 000001", pack_last(base, 6));
    end
    tests++;
    if (low_cnt - low0 != 8) begin
      fails++; $display("FAIL block_ready_low: got %0d cycles required 8", low_cnt - low0);
    end
  endtask

  task automatic test_corrupt();
    int base;
    load_block6();
    syms[2] = 2'b10;
    base = obits.size();
    send_seq(0, 6, 1'b1, 1'b0);
    wait_last(60);
    tests++;
    if (pack_bits(base, 6) !== 64'b101100 || obits.size() - base != 6) begin
      fails++;
      $display("FAIL corrupt_bits: got %b (%0d bits) required 101100 (6 bits)",
               pack_bits(base, 6), obits.size() - base);
    end
  endtask

  task automatic test_single();
    int base;
    syms[0] = 2'b11;
`ifdef VITERBI_ERASURE_EN
    ers[0] = 2'b00;
`endif
    base = obits.size();
    send_seq(0, 1, 1'b1, 1'b0);
    wait_last(30);
    tests++;
    if (obits.size() - base != 1 || obits[base] !== 1'b1 || olast[base] !== 1'b1) begin
      fails++;
      $display("FAIL single_block: got %0d bits first=%0b last=%0b required 1 bit 1 last 1",
               obits.size() - base, obits[base], olast[base]);
    end
  endtask

  task automatic test_stream();
    int base;
    logic [63:0] src;
    src = {24'h0, 38'h1A5B3CE1A7, 2'b00};
    encode(src, 0, 40);
    base = obits.size();
    send_seq(0, 40, 1'b1, 1'b0);
    wait_last(100);
    tests++;
    if (obits.size() - base != 40) begin
      fails++; $display("FAIL stream_count: got %0d required 40", obits.size() - base);
    end
    tests++;
    if (ocyc[base] - acc_cyc != 16) begin
      fails++; $display("FAIL stream_latency: got %0d cycles required 16", ocyc[base] - acc_cyc);
    end
    tests++;
    if (ocyc[base+39] - ocyc[base] != 39) begin
      fails++; $display("FAIL stream_rate: got span %0d required 39", ocyc[base+39] - ocyc[base]);
    end
    tests++;
    if (pack_bits(base, 40) !== src) begin
      fails++; $display("FAIL stream_bits: got %h required %h", pack_bits(base, 40), src);
    end
    tests++;
    if (pack_last(base, 40) !== 64'h1) begin
      fails++; $display("FAIL stream_last: got %h required 1", pack_last(base, 40));
    end
  endtask

  task automatic test_back_to_back();
    int base;
    load_block6();
    syms[6]  = 2'b00; syms[7]  = 2'b11; syms[8]  = 2'b01;
    syms[9]  = 2'b01; syms[10] = 2'b11; syms[11] = 2'b00;
`ifdef VITERBI_ERASURE_EN
    for (int i = 6; i < 12; i++) ers[i] = 2'b00;
`endif
    base = obits.size();
    send_seq(0, 6, 1'b1, 1'b1);
    send_seq(6, 6, 1'b1, 1'b0);
    wait_last(60);
    tests++;
    if (obits.size() - base != 12) begin
      fails++; $display("FAIL b2b_count: got %0d required 12", obits.size() - base);
    end
    tests++;
    if (pack_bits(base, 12) !== 64'b101100011000) begin
      fails++; $display("FAIL b2b_bits: got %b required 101100011000", pack_bits(base, 12));
    end
    tests++;
    if (pack_last(base, 12) !== 64'b000001000001) begin
      fails++; $display("FAIL b2b_last: got %b required 000001000001", pack_last(base, 12));
    end
  endtask

  task automatic test_async_reset();
    int base;
    logic [63:0] src;
    src = {24'h0, 38'h1A5B3CE1A7, 2'b00};
    encode(src, 0, 40);
    send_seq(0, 20, 1'b0, 1'b1);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL arst_pre_run: out_valid got %0b required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, out_bit, out_last} !== 4'b1000) begin
      fails++;
      $display("FAIL arst_outputs: got rdy/vld/bit/last %b required 1000",
               {in_ready, out_valid, out_bit, out_last});
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    base = obits.size();
    repeat (30) @(negedge clk);
    tests++;
    if (obits.size() != base) begin
      fails++; $display("FAIL arst_no_output: got %0d bits required 0", obits.size() - base);
    end
    load_block6();
    base = obits.size();
    send_seq(0, 6, 1'b1, 1'b0);
    wait_last(60);
    tests++;
    if (pack_bits(base, 6) !== 64'b101100 || pack_last(base, 6) !== 64'b000001) begin
      fails++;
      $display("FAIL arst_next_block: got bits %b last %b required 101100 000001",
               pack_bits(base, 6), pack_last(base, 6));
    end
  endtask

`ifdef VITERBI_ERASURE_EN
  task automatic test_erasure();
    int base;
    logic [63:0] src;
    src = {44'h0, 18'h2C9B5, 2'b00};
    encode(src, 0, 20);
    for (int i = 1; i < 20; i += 2) begin
      ers[i] = 2'b01;
      syms[i][0] = ~syms[i][0];
    end
    base = obits.size();
    send_seq(0, 20, 1'b1, 1'b0);
    wait_last(80);
    tests++;
    if (obits.size() - base != 20 || pack_bits(base, 20) !== src) begin
      fails++;
      $display("FAIL erasure_bits: got %h (%0d bits) required %h (20 bits)",
               pack_bits(base, 20), obits.size() - base, src);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_block();
    test_corrupt();
    test_single();
    test_stream();
    test_back_to_back();
    test_async_reset();
`ifdef VITERBI_ERASURE_EN
    test_erasure();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/viterbi_decoder.md
# viterbi_decoder

Parametrised hard-decision Viterbi decoder for rate-1/2 convolutional codes, with configurable constraint length, generator polynomials and survivor depth. It uses register-exchange survivor memory. It accepts one 2-bit coded symbol per cycle over a valid/ready handshake and emits one decoded bit per accepted symbol once the survivors are full. An explicit end-of-block flush drains the remaining bits. It sits downstream of the channel/deinterleaver and upstream of the payload sink.

## Interface
- `K`, 3: constraint length, legal 3..7; 2^(K-1) states
- `G0`, 7: generator for coded bit 0 (`in_sym[1]`), K bits, MSB = current input
- `G1`, 5: generator for coded bit 1 (`in_sym[0]`)
- `D`, 15: survivor depth in symbols, legal 4..64
- `PM_W`, 6: path-metric width, ≥ 4
- `clk` input 1: clock
- `rst` input 1: reset, asynchronous, active-high
- `in_valid` input 1: `in_sym` valid
- `in_ready` output 1: decoder accepts a symbol
- `in_sym` input 2: hard-decision coded pair {c0,c1}
- `in_last` input 1: qualifies the final symbol of a block
- `out_valid` output 1: `out_bit` valid, single-cycle pulse, no backpressure
- `out_bit` output 1: decoded bit, oldest first
- `out_last` output 1: high with the final decoded bit of a block

## Operation
- State s = {u[t-1]..u[t-K+1]}, with u[t-1] at the MSB. Coded bits: c0 = ^(G0 & {u,s}), c1 = ^(G1 & {u,s}). Next state = {u, s[K-2:1]}.
- Branch metric: Hamming distance between `in_sym` and the expected pair, range 0..2.
- ACS for each state n, using the predecessors {n[K-3:0],0} and {n[K-3:0],1}:
  - Candidates are computed with saturating add, saturating at 2^PM_W-1.
  - The smaller candidate wins; on a tie, the predecessor ending in 0 wins.
  - The survivor becomes {pred_survivor[D-2:0], n[K-2]}.
- Normalisation: after each ACS, subtract the minimum new metric from every metric, so the minimum is always 0.
- Metric init (at reset and on block end): state 0 = 0; all others = 2^PM_W-1. All survivors = 0. Fill counter = 0.
- Best state: the minimum metric; on a tie, the lowest index.
- FSM:
  - FILL: accept symbols and increment the fill counter (saturates at D). No output while the count is < D.
  - RUN: entered when fill = D. For each accepted symbol, emit bit D-1 of the best state's survivor.
  - FLUSH: entered after a symbol with `in_last` is accepted.
    - Latch the best state and freeze its survivor.
    - `in_ready` = 0.
    - Emit the remaining held bits, oldest to newest, one per cycle.
    - Remaining count = min(fill, D-1) if that symbol produced a RUN output, else fill.
    - `out_last` is high on the final bit.
    - Then re-init the metrics and go to FILL.
- Total decoded bits per block = number of symbols accepted in that block.
- An `in_last` symbol accepted with fill = 0 (a one-symbol block) emits exactly 1 bit.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `out_bit` = 0, `out_last` = 0.
  - FSM = FILL, metrics and survivors initialised.
- Handshake: a transfer occurs on a rising edge with `in_valid & in_ready`. `in_ready` = 1 in FILL/RUN and 0 in FLUSH.
- ACS, normalisation and survivor update complete at the accepting edge.
- Best-state search and the output register update on the next edge. `out_valid` is high in the cycle after the ACS edge.
- Throughput is 1 symbol/cycle in FILL/RUN.
- FLUSH emits one bit per cycle, starting the cycle after the `in_last` output slot.
- `in_ready` returns to 1 in the cycle after `out_last`.
- Reset mid-block (async) discards all state immediately. No partial `out_last` is produced.

## Configuration
- `VITERBI_ERASURE_EN` defined:
  - Adds input port `in_erase[1:0]`, sampled with `in_sym`.
  - An erased position contributes 0 to the branch metric (depuncturing support).
  - Both positions erased gives an all-zero branch metric.
- `VITERBI_ERASURE_EN` undefined: the port is absent and every bit is counted.

## Test plan
- K=3, G=7/5, D=15; block of symbols 11,10,00,01,01,11 with `in_last` on the last symbol -> 6 bits 1,0,1,1,0,0, `out_last` on the 6th, `in_ready` low only during FLUSH.
- Same block with the third symbol corrupted to 10 -> identical output 1,0,1,1,0,0.
- 40-symbol random stream (encoded with tail), continuous `in_valid` -> first `out_valid` 16 cycles after the first accept; total 40 bits match the source, one per cycle.
- Back-to-back blocks: `in_valid` held high across a FLUSH -> no symbol accepted while `in_ready`=0; the second block decodes independently from state 0.
- Async `rst` pulse mid-RUN -> outputs go to reset values within the same cycle; the next block decodes correctly.
- With `VITERBI_ERASURE_EN`: rate-2/3 punctured stream with erasures on alternate c1 positions -> error-free decode of a 20-bit payload.
